// File: rtl/regfile_op_sequencer_if.sv
// Port bundle between regfile_op_sequencer and its environment: op handshake,
// register file read/write ports and ALU launch/result signals.
interface regfile_op_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int OP_W   = 4
);
   logic              op_valid;
   logic              op_ready;
   logic [ADDR_W-1:0] op_rs1;
   logic [ADDR_W-1:0] op_rs2;
   logic [ADDR_W-1:0] op_rd;
   logic [OP_W-1:0]   op_code;

   logic [ADDR_W-1:0] rf_rd_reg1;
   logic [DATA_W-1:0] rf_rd_data1;
   logic [ADDR_W-1:0] rf_rd_reg2;
   logic [DATA_W-1:0] rf_rd_data2;
   logic              rf_wr_en;
   logic [ADDR_W-1:0] rf_wr_reg;
   logic [DATA_W-1:0] rf_wr_data;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic              alu_start;
   logic [DATA_W-1:0] alu_result;
   logic              alu_done;

   logic              done;
   logic              timeout_err;
   logic              busy;

   // Sequencer view: it initiates on the register file and ALU.
   modport master (
      input  op_valid, op_rs1, op_rs2, op_rd, op_code,
      input  rf_rd_data1, rf_rd_data2, alu_result, alu_done,
      output op_ready, rf_rd_reg1, rf_rd_reg2, rf_wr_en, rf_wr_reg, rf_wr_data,
      output alu_a, alu_b, alu_op, alu_start, done, timeout_err, busy
   );

   modport slave (
      output op_valid, op_rs1, op_rs2, op_rd, op_code,
      output rf_rd_data1, rf_rd_data2, alu_result, alu_done,
      input  op_ready, rf_rd_reg1, rf_rd_reg2, rf_wr_en, rf_wr_reg, rf_wr_data,
      input  alu_a, alu_b, alu_op, alu_start, done, timeout_err, busy
   );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Three-register op sequencer: read rs1/rs2, run the ALU, write rd back.
// Optional macro RF_R0_ZERO_EN: register 0 reads as zero and is never written.
module regfile_op_sequencer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int OP_W    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_op_sequencer_if.master  bus
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rs1_q, rs1_d;
   logic [ADDR_W-1:0] rs2_q, rs2_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [OP_W-1:0]   code_q, code_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;

   logic [DATA_W-1:0] opnd1, opnd2;
   logic              wr_allow;

`ifdef RF_R0_ZERO_EN
   assign opnd1    = (rs1_q == '0) ? '0 : bus.rf_rd_data1;
   assign opnd2    = (rs2_q == '0) ? '0 : bus.rf_rd_data2;
   assign wr_allow = (rd_q != '0);
`else
   assign opnd1    = bus.rf_rd_data1;
   assign opnd2    = bus.rf_rd_data2;
   assign wr_allow = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         code_q    <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         code_q    <= code_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      code_d    = code_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.op_valid) begin
               rs1_d     = bus.op_rs1;
               rs2_d     = bus.op_rs2;
               rd_d      = bus.op_rd;
               code_d    = bus.op_code;
               timeout_d = 1'b0;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            alu_a_d  = opnd1;
            alu_b_d  = opnd2;
            alu_op_d = code_q;
            cnt_d    = '0;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            // Done is checked before the limit, so a result on the last allowed cycle still commits.
            if (bus.alu_done) begin
               wr_data_d = bus.alu_result;
               state_d   = S_WRITE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.op_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.alu_start = 1'b0;
      bus.rf_wr_en  = 1'b0;
      bus.done      = 1'b0;
      unique case (state_q)
         S_IDLE:  bus.op_ready = 1'b1;
         S_READ:  bus.busy = 1'b1;
         S_EXEC: begin
            bus.busy      = 1'b1;
            bus.alu_start = (cnt_q == '0);
         end
         S_WRITE: begin
            bus.busy     = 1'b1;
            bus.rf_wr_en = wr_allow;
            bus.done     = 1'b1;
         end
         default: bus.op_ready = 1'b1;
      endcase
   end

   assign bus.rf_rd_reg1  = rs1_q;
   assign bus.rf_rd_reg2  = rs2_q;
   assign bus.rf_wr_reg   = rd_q;
   assign bus.rf_wr_data  = wr_data_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.timeout_err = timeout_q;
endmodule
